// File: rtl/fifo_pkg.sv
// Shared async-FIFO definitions: pointer width and Gray/binary conversion helpers.
// Used by both the read-side and write-side pointer logic.
package fifo_pkg;

    localparam int ADDRESS_SIZE = 3;
    localparam int FIFO_PTR_W   = ADDRESS_SIZE + 1;
    localparam int CONV_W       = 32;

    // Callers zero-extend narrower pointers; leading zeros map to zeros in both directions.
    function automatic logic [CONV_W-1:0] bin2gray(input logic [CONV_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic logic [CONV_W-1:0] gray2bin(input logic [CONV_W-1:0] gray);
        logic [CONV_W-1:0] bin;
        bin[CONV_W-1] = gray[CONV_W-1];
        for (int i = CONV_W - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/read_pointer_empty_gray_to_binary.sv
// Combinational Gray-to-binary converter of configurable width.
module gray_to_binary
    import fifo_pkg::*;
#(
    parameter int W = FIFO_PTR_W
) (
    input  logic [W-1:0] gray_i,
    output logic [W-1:0] bin_o
);

    // Width-agnostic conversion through the shared helper.
    always_comb begin
        bin_o = W'(gray2bin(CONV_W'(gray_i)));
    end

endmodule

// File: rtl/read_pointer_empty.sv
// Read-domain pointer, empty flag, occupancy count and underflow pulse for the async FIFO.
// Optional read_almost_empty_o is built only when READ_ALMOST_EMPTY_EN is defined.
module read_pointer_empty
    import fifo_pkg::*;
#(
    parameter int address_size       = ADDRESS_SIZE,
    parameter int almost_empty_level = 1
) (
    input  logic                    read_clk_i,
    input  logic                    read_reset_n_i,
    input  logic                    read_en_i,
    input  logic [address_size:0]   write_to_read_pointer_i,
    output logic [address_size-1:0] read_address_o,
    output logic [address_size:0]   read_pointer_o,
    output logic                    read_empty_o,
    output logic [address_size:0]   read_count_o,
    output logic                    read_underflow_o
`ifdef READ_ALMOST_EMPTY_EN
    ,
    output logic                    read_almost_empty_o
`endif
);

    localparam int PTR_W = address_size + 1;

    if (almost_empty_level < 0 || almost_empty_level > (1 << address_size)) begin : g_level_check
        $error("almost_empty_level out of range");
    end

    logic [PTR_W-1:0] bin_q, bin_d;
    logic [PTR_W-1:0] gray_q, gray_d;
    logic [PTR_W-1:0] count_q, count_d;
    logic             empty_q, empty_d;
    logic             underflow_q, underflow_d;
    logic             accept_s;
    logic [PTR_W-1:0] wbin_s;

    gray_to_binary #(.W(PTR_W)) u_wptr_conv (
        .gray_i (write_to_read_pointer_i),
        .bin_o  (wbin_s)
    );

    // Next-state: advance on accepted read, compare the advanced pointer with the synced write pointer.
    always_comb begin
        accept_s    = read_en_i & ~empty_q;
        bin_d       = bin_q + {{address_size{1'b0}}, accept_s};
        gray_d      = PTR_W'(bin2gray(CONV_W'(bin_d)));
        empty_d     = (gray_d == write_to_read_pointer_i);
        count_d     = wbin_s - bin_d;
        underflow_d = read_en_i & empty_q;
    end

    // State registers; reset leaves the FIFO looking empty.
    always_ff @(posedge read_clk_i or negedge read_reset_n_i) begin
        if (!read_reset_n_i) begin
            bin_q       <= '0;
            gray_q      <= '0;
            count_q     <= '0;
            empty_q     <= 1'b1;
            underflow_q <= 1'b0;
        end else begin
            bin_q       <= bin_d;
            gray_q      <= gray_d;
            count_q     <= count_d;
            empty_q     <= empty_d;
            underflow_q <= underflow_d;
        end
    end

    assign read_address_o   = bin_q[address_size-1:0];
    assign read_pointer_o   = gray_q;
    assign read_empty_o     = empty_q;
    assign read_count_o     = count_q;
    assign read_underflow_o = underflow_q;

`ifdef READ_ALMOST_EMPTY_EN
    localparam logic [PTR_W-1:0] AE_LEVEL = PTR_W'(almost_empty_level);

    logic almost_empty_q;

    // Almost-empty tracks the post-edge occupancy, so it is exact in the same cycle as count.
    always_ff @(posedge read_clk_i or negedge read_reset_n_i) begin
        if (!read_reset_n_i) begin
            almost_empty_q <= 1'b1;
        end else begin
            almost_empty_q <= (count_d <= AE_LEVEL);
        end
    end

    assign read_almost_empty_o = almost_empty_q;
`endif

endmodule

// File: tb/tb_read_pointer_empty.sv
// Self-checking bench for read_pointer_empty (address_size=3) with an occupancy-based reference model.
module tb_read_pointer_empty;

    logic       clk;
    logic       rst_n;
    logic       read_en;
    logic [3:0] wptr;
    logic [2:0] read_address;
    logic [3:0] read_pointer;
    logic       read_empty;
    logic [3:0] read_count;
    logic       read_underflow;
`ifdef READ_ALMOST_EMPTY_EN
    logic       read_almost_empty;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: total words read / written so far, plus registered flags.
    int   m_rd;
    int   m_wr;
    int   m_count;
    logic m_empty;
    logic m_under;

    read_pointer_empty #(.address_size(3), .almost_empty_level(2)) dut (
        .read_clk_i              (clk),
        .read_reset_n_i          (rst_n),
        .read_en_i               (read_en),
        .write_to_read_pointer_i (wptr),
        .read_address_o          (read_address),
        .read_pointer_o          (read_pointer),
        .read_empty_o            (read_empty),
        .read_count_o            (read_count),
        .read_underflow_o        (read_underflow)
`ifdef READ_ALMOST_EMPTY_EN
        ,
        .read_almost_empty_o     (read_almost_empty)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] gray4(input int v);
        int u;
        u = v % 16;
        return 4'(u ^ (u / 2));
    endfunction

    function automatic int occ();
        return ((m_wr - m_rd) % 16 + 16) % 16;
    endfunction

    task automatic do_reset(input int wr);
        read_en = 1'b0;
        wptr    = gray4(wr);
        rst_n   = 1'b0;
        @(negedge clk);
        rst_n   = 1'b1;
        m_rd = 0; m_wr = wr; m_count = 0; m_empty = 1'b1; m_under = 1'b0;
    endtask

    task automatic tick(input logic en, input int wr);
        read_en = en;
        m_wr    = wr;
        wptr    = gray4(wr);
        m_under = en && m_empty;
        if (en && !m_empty) m_rd++;
        m_count = occ();
        m_empty = (m_count == 0);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; read_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wptr = gray4(i * 3 + 1);
            @(posedge clk); #1;
            n_tests++;
            if ({read_address, read_pointer, read_empty, read_count, read_underflow} !== {3'd0, 4'd0, 1'b1, 4'd0, 1'b0}) begin
                n_fail++;
                $display("FAIL reset cyc%0d: addr=%0d ptr=%b empty=%b count=%0d uf=%b, need 0 0000 1 0 0",
                         i, read_address, read_pointer, read_empty, read_count, read_underflow);
            end
`ifdef READ_ALMOST_EMPTY_EN
            n_tests++;
            if (read_almost_empty !== 1'b1) begin
                n_fail++;
                $display("FAIL reset_ae: got %b need 1", read_almost_empty);
            end
`endif
        end
    endtask

    task automatic test_single_word();
        do_reset(0);
        tick(1'b0, 1);
        n_tests++;
        if (read_empty !== 1'b0 || read_count !== 4'd1) begin
            n_fail++;
            $display("FAIL single_fill: empty=%b count=%0d, need 0 1", read_empty, read_count);
        end
        tick(1'b1, 1);
        n_tests++;
        if ({read_address, read_pointer, read_empty, read_count} !== {3'd1, 4'b0001, 1'b1, 4'd0}) begin
            n_fail++;
            $display("FAIL single_read: addr=%0d ptr=%b empty=%b count=%0d, need 1 0001 1 0",
                     read_address, read_pointer, read_empty, read_count);
        end
    endtask

    task automatic test_underflow();
        for (int i = 0; i < 2; i++) begin
            tick(1'b1, 1);
            n_tests++;
            if (read_underflow !== 1'b1 || read_pointer !== 4'b0001 || read_count !== 4'd0) begin
                n_fail++;
                $display("FAIL underflow%0d: uf=%b ptr=%b count=%0d, need 1 0001 0",
                         i, read_underflow, read_pointer, read_count);
            end
        end
        tick(1'b0, 1);
        n_tests++;
        if (read_underflow !== 1'b0) begin
            n_fail++;
            $display("FAIL underflow_clear: uf=%b need 0", read_underflow);
        end
    endtask

    task automatic test_full_wrap();
        do_reset(0);
        tick(1'b0, 8);
        n_tests++;
        if (read_count !== 4'd8 || read_empty !== 1'b0 || read_address !== 3'd0) begin
            n_fail++;
            $display("FAIL full: count=%0d empty=%b addr=%0d, need 8 0 0", read_count, read_empty, read_address);
        end
        for (int k = 1; k <= 8; k++) begin
            tick(1'b1, 8);
            n_tests++;
            if (read_address !== 3'(k % 8) || read_empty !== (k == 8) || read_count !== 4'(8 - k)) begin
                n_fail++;
                $display("FAIL drain%0d: addr=%0d empty=%b count=%0d, need %0d %0d %0d",
                         k, read_address, read_empty, read_count, k % 8, (k == 8), 8 - k);
            end
        end
        n_tests++;
        if (read_pointer !== 4'b1100) begin
            n_fail++;
            $display("FAIL wrap_ptr1: got %b need 1100", read_pointer);
        end
        tick(1'b0, 16);
        n_tests++;
        if (read_count !== 4'd8 || read_empty !== 1'b0) begin
            n_fail++;
            $display("FAIL refill: count=%0d empty=%b, need 8 0", read_count, read_empty);
        end
        for (int k = 0; k < 8; k++) tick(1'b1, 16);
        n_tests++;
        if (read_pointer !== 4'b0000 || read_empty !== 1'b1 || read_address !== 3'd0) begin
            n_fail++;
            $display("FAIL wrap_ptr2: ptr=%b empty=%b addr=%0d, need 0000 1 0", read_pointer, read_empty, read_address);
        end
    endtask

    task automatic test_reset_mid_read();
        do_reset(0);
        tick(1'b0, 5);
        tick(1'b1, 5);
        tick(1'b0, 5 + 1);
        n_tests++;
        if (read_count !== 4'd5 || read_address !== 3'd1) begin
            n_fail++;
            $display("FAIL pre_reset: count=%0d addr=%0d, need 5 1", read_count, read_address);
        end
        #3 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({read_address, read_pointer, read_empty, read_count, read_underflow} !== {3'd0, 4'd0, 1'b1, 4'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL async_reset: addr=%0d ptr=%b empty=%b count=%0d uf=%b, need 0 0000 1 0 0",
                     read_address, read_pointer, read_empty, read_count, read_underflow);
        end
        #2 rst_n = 1'b1;
        m_rd = 0; m_wr = 6; m_count = 0; m_empty = 1'b1; m_under = 1'b0;
        tick(1'b1, 6);
        n_tests++;
        if (read_underflow !== 1'b1 || read_empty !== 1'b0 || read_count !== 4'd6 || read_address !== 3'd0) begin
            n_fail++;
            $display("FAIL post_reset_read: uf=%b empty=%b count=%0d addr=%0d, need 1 0 6 0",
                     read_underflow, read_empty, read_count, read_address);
        end
    endtask

`ifdef READ_ALMOST_EMPTY_EN
    task automatic test_almost_empty();
        logic exp_ae [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        do_reset(0);
        for (int k = 0; k < 5; k++) begin
            tick(k != 0, 4);
            n_tests++;
            if (read_almost_empty !== exp_ae[k] || read_count !== 4'(4 - k)) begin
                n_fail++;
                $display("FAIL almost_empty%0d: ae=%b count=%0d, need %b %0d",
                         k, read_almost_empty, read_count, exp_ae[k], 4 - k);
            end
        end
    endtask
`endif

    task automatic test_random();
        int   o;
        int   wr;
        logic en;
        do_reset(0);
        for (int c = 0; c < 400; c++) begin
            o  = occ();
            wr = m_wr;
            if ($urandom_range(0, 2) == 0) wr = m_wr + int'($urandom_range(0, 8 - o));
            en = ($urandom_range(0, 9) < 6);
            tick(en, wr);
            n_tests++;
            if ({read_address, read_pointer, read_empty, read_count, read_underflow} !==
                {3'(m_rd % 8), gray4(m_rd), m_empty, 4'(m_count), m_under}) begin
                n_fail++;
                $display("FAIL random%0d: addr=%0d ptr=%b empty=%b count=%0d uf=%b, need %0d %b %b %0d %b",
                         c, read_address, read_pointer, read_empty, read_count, read_underflow,
                         m_rd % 8, gray4(m_rd), m_empty, m_count, m_under);
            end
`ifdef READ_ALMOST_EMPTY_EN
            n_tests++;
            if (read_almost_empty !== (m_count <= 2)) begin
                n_fail++;
                $display("FAIL random_ae%0d: got %b need %b", c, read_almost_empty, (m_count <= 2));
            end
`endif
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        read_en = 1'b0;
        wptr    = 4'd0;
        test_reset();
        test_single_word();
        test_underflow();
        test_full_wrap();
        test_reset_mid_read();
`ifdef READ_ALMOST_EMPTY_EN
        test_almost_empty();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
